// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite slave SRAM. Holds 2^ADDR_WIDTH 32-bit words and
//               serves byte, halfword and word transfers through byte-lane
//               write enables. Each OKAY transfer gets WAIT_STATES extra
//               data-phase cycles. Illegal accesses get a two-cycle ERROR
//               response and never write memory. Write data still in its
//               final data-phase cycle is merged into a back-to-back read
//               of the same word.
// Ports       : HCLK, HRESETn             clock, async active-low reset
//               HSEL, HADDR, HTRANS,      address phase
//               HWRITE, HSIZE, HREADY
//               HBURST, HPROT, HMASTLOCK  accepted, ignored
//               HWDATA                    write data (data phase)
//               HRDATA, HREADYOUT, HRESP  slave response
// Revision    : 1.0  initial release
// ============================================================================
module ahb_sram_slave #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);

    localparam int         c_depth      = 1 << ADDR_WIDTH;
    localparam logic [1:0] c_resp_okay  = 2'b00;
    localparam logic [1:0] c_resp_error = 2'b01;
    // The counter counts WAIT_STATES-1 down to 0, one cycle per WAIT cycle.
    localparam logic [3:0] c_wait_load  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic                    hreadyout_q;
    logic [1:0]              hresp_q;
    logic [31:0]             hrdata_q;

    // Data-phase registers of the transfer currently being served.
    logic                    dp_valid_q;
    logic                    dp_write_q;
    logic [ADDR_WIDTH-1:0]   dp_addr_q;
    logic [3:0]              dp_be_q;

    logic [31:0]             mem_q [c_depth];

    logic                    w_accept;
    logic                    w_final;
    logic                    w_capture;
    logic                    w_legal;
    logic                    w_align_ok;
    logic [3:0]              w_be;
    logic [ADDR_WIDTH-1:0]   w_word_idx;
    logic                    w_commit;
    logic                    w_fwd;
    logic [31:0]             w_read_word;
    logic                    w_unused_ok;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign w_accept   = HSEL & HREADY & HTRANS[1];
    // Only IDLE and ERR2 are cycles in which HREADYOUT is high, so they are
    // the only cycles in which a new address phase can complete.
    assign w_final    = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign w_capture  = HREADY & w_final;
    assign w_word_idx = HADDR[ADDR_WIDTH+1:2];

    always_comb begin
        w_align_ok = 1'b1;
        w_be       = 4'b1111;
        case (HSIZE)
            3'b000: w_be = 4'b0001 << HADDR[1:0];
            3'b001: begin
                w_align_ok = ~HADDR[0];
                w_be       = HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: w_align_ok = (HADDR[1:0] == 2'b00);
            default: w_be = 4'b1111;
        endcase
    end

    // Shift rather than slice so the check also holds when ADDR_WIDTH+2 = 32.
    assign w_legal = ((HADDR >> (ADDR_WIDTH + 2)) == 32'd0) &&
                     (HSIZE <= 3'd2) && w_align_ok;

    // A legal write commits on the edge that ends its HREADYOUT=1 cycle.
    assign w_commit = dp_valid_q & dp_write_q & (state_q == S_IDLE);

    // Read in the same edge as a committing write to the same word: take the
    // write's lanes from the bus instead of the not-yet-updated array.
    assign w_fwd       = w_commit && (dp_addr_q == w_word_idx);
    assign w_read_word = w_fwd ? merge_lanes(mem_q[w_word_idx], HWDATA, dp_be_q)
                               : mem_q[w_word_idx];

    assign w_unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    // Response FSM with registered HREADYOUT/HRESP.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= c_resp_okay;
        end else begin
            case (state_q)
                S_IDLE, S_ERR2: begin
                    if (w_accept && !w_legal) begin
                        state_q     <= S_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= c_resp_error;
                    end else if (w_accept && (WAIT_STATES != 0)) begin
                        state_q     <= S_WAIT;
                        cnt_q       <= c_wait_load;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= c_resp_okay;
                    end else begin
                        state_q     <= S_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= c_resp_okay;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_IDLE;
                        hreadyout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= c_resp_error;
                end
                default: begin
                    state_q     <= S_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= c_resp_okay;
                end
            endcase
        end
    end

    // Data-phase capture; held whenever the bus is stalled.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_be_q    <= 4'd0;
        end else if (w_capture) begin
            dp_valid_q <= w_accept & w_legal;
            dp_write_q <= HWRITE;
            dp_addr_q  <= w_word_idx;
            dp_be_q    <= w_be;
        end
    end

    // HRDATA is loaded on the edge that starts the read's last data-phase
    // cycle: the accept edge with no wait states, otherwise the edge that
    // leaves WAIT.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hrdata_q <= 32'd0;
        end else if ((WAIT_STATES == 0) && w_capture && w_accept && w_legal && !HWRITE) begin
            hrdata_q <= w_read_word;
        end else if ((state_q == S_WAIT) && (cnt_q == 4'd0) && dp_valid_q && !dp_write_q) begin
            hrdata_q <= mem_q[dp_addr_q];
        end
    end

    // Memory array is intentionally not reset.
    always_ff @(posedge HCLK) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_be_q[i]) begin
                    mem_q[dp_addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA    = hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule
`default_nettype wire
